// File: rtl/tbus_arbiter.sv
// Arbitrates load/store requesters onto a single-outstanding tbus; request reaches the bus one cycle after grant.
// Requester ready only in IDLE; responses pass through with no added cycle; ldu_flush drops or drains an in-flight load.
module tbus_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ldu_tbus_index_valid,
  output logic        ldu_tbus_index_ready,
  input  logic [63:0] ldu_tbus_index,
  input  logic [63:0] ldu_tbus_write_data,
  input  logic [63:0] ldu_tbus_write_mask,
  input  logic [1:0]  ldu_tbus_operation_type,
  output logic [63:0] ldu_tbus_read_data,
  output logic        ldu_tbus_operation_done,
  input  logic        ldu_flush,
  input  logic        stu_tbus_index_valid,
  output logic        stu_tbus_index_ready,
  input  logic [63:0] stu_tbus_index,
  input  logic [63:0] stu_tbus_write_data,
  input  logic [63:0] stu_tbus_write_mask,
  input  logic [1:0]  stu_tbus_operation_type,
  output logic [63:0] stu_tbus_read_data,
  output logic        stu_tbus_operation_done,
  output logic        tbus_index_valid,
  input  logic        tbus_index_ready,
  output logic [63:0] tbus_index,
  output logic [63:0] tbus_write_data,
  output logic [63:0] tbus_write_mask,
  output logic [1:0]  tbus_operation_type,
  input  logic [63:0] tbus_read_data,
  input  logic        tbus_operation_done,
  output logic        arb_busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [63:0] index;
    logic [63:0] write_data;
    logic [63:0] write_mask;
    logic [1:0]  operation_type;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q, req_nxt;
  logic   owner, owner_nxt;
  logic   last_grant, last_grant_nxt;
  logic   ld_elig, st_elig, grant_ldu, grant_stu, flush_own;

  // last_grant: 0 = LDU, 1 = STU; STU wins a tie only when LDU had the previous grant
  assign ld_elig   = ldu_tbus_index_valid & ~ldu_flush;
  assign st_elig   = stu_tbus_index_valid;
  assign grant_stu = st_elig & (~ld_elig | (RR_EN & ~last_grant));
  assign grant_ldu = ld_elig & ~grant_stu;
  assign flush_own = ldu_flush & ~owner;
  assign arb_busy  = (state != IDLE);

  always_comb begin
    state_nxt               = state;
    owner_nxt               = owner;
    last_grant_nxt          = last_grant;
    req_nxt                 = req_q;
    ldu_tbus_index_ready    = 1'b0;
    stu_tbus_index_ready    = 1'b0;
    ldu_tbus_operation_done = 1'b0;
    stu_tbus_operation_done = 1'b0;
    ldu_tbus_read_data      = '0;
    stu_tbus_read_data      = '0;
    tbus_index_valid        = 1'b0;
    tbus_index              = '0;
    tbus_write_data         = '0;
    tbus_write_mask         = '0;
    tbus_operation_type     = '0;

    case (state)
      IDLE: begin
        // reset gating keeps the combinational readies low while reset is held
        if (!reset && (grant_ldu || grant_stu)) begin
          ldu_tbus_index_ready = grant_ldu;
          stu_tbus_index_ready = grant_stu;
          owner_nxt            = grant_stu;
          last_grant_nxt       = grant_stu;
          if (grant_stu) begin
            req_nxt.index          = stu_tbus_index;
            req_nxt.write_data     = stu_tbus_write_data;
            req_nxt.write_mask     = stu_tbus_write_mask;
            req_nxt.operation_type = stu_tbus_operation_type;
          end else begin
            req_nxt.index          = ldu_tbus_index;
            req_nxt.write_data     = ldu_tbus_write_data;
            req_nxt.write_mask     = ldu_tbus_write_mask;
            req_nxt.operation_type = ldu_tbus_operation_type;
          end
          state_nxt = REQ;
        end
      end
      REQ: begin
        tbus_index_valid    = 1'b1;
        tbus_index          = req_q.index;
        tbus_write_data     = req_q.write_data;
        tbus_write_mask     = req_q.write_mask;
        tbus_operation_type = req_q.operation_type;
        if (flush_own)
          state_nxt = tbus_index_ready ? DRAIN : IDLE;
        else if (tbus_index_ready)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (tbus_operation_done) begin
          state_nxt = IDLE;
          if (owner) begin
            stu_tbus_operation_done = 1'b1;
            stu_tbus_read_data      = tbus_read_data;
          end else if (!ldu_flush) begin
            ldu_tbus_operation_done = 1'b1;
            ldu_tbus_read_data      = tbus_read_data;
          end
        end else if (flush_own) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (tbus_operation_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      req_q      <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      req_q      <= req_nxt;
    end
  end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Directed scoreboard bench for tbus_arbiter; a fixed-priority copy shares the inputs for the contention case.
module tb_tbus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ldu_tbus_index_valid, ldu_tbus_index_ready, ldu_tbus_operation_done, ldu_flush;
  logic [63:0] ldu_tbus_index, ldu_tbus_write_data, ldu_tbus_write_mask, ldu_tbus_read_data;
  logic [1:0]  ldu_tbus_operation_type;
  logic        stu_tbus_index_valid, stu_tbus_index_ready, stu_tbus_operation_done;
  logic [63:0] stu_tbus_index, stu_tbus_write_data, stu_tbus_write_mask, stu_tbus_read_data;
  logic [1:0]  stu_tbus_operation_type;
  logic        tbus_index_valid, tbus_index_ready, tbus_operation_done, arb_busy;
  logic [63:0] tbus_index, tbus_write_data, tbus_write_mask, tbus_read_data;
  logic [1:0]  tbus_operation_type;

  logic        f_ldu_ready, f_stu_ready, f_ldu_done, f_stu_done, f_tbus_valid, f_busy;
  logic [63:0] f_ldu_rd, f_stu_rd, f_tbus_index, f_tbus_wd, f_tbus_wm;
  logic [1:0]  f_tbus_op;

  typedef struct packed {
    logic        own;
    logic [63:0] idx;
    logic [1:0]  op;
    logic [63:0] wd;
    logic [63:0] wm;
  } exp_t;

  exp_t exp_q[$];
  exp_t fp_q[$];
  int   n_checks;
  int   n_pass;

  always #5 clock = ~clock;

  tbus_arbiter #(.RR_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .ldu_tbus_index_valid(ldu_tbus_index_valid), .ldu_tbus_index_ready(ldu_tbus_index_ready),
    .ldu_tbus_index(ldu_tbus_index), .ldu_tbus_write_data(ldu_tbus_write_data),
    .ldu_tbus_write_mask(ldu_tbus_write_mask), .ldu_tbus_operation_type(ldu_tbus_operation_type),
    .ldu_tbus_read_data(ldu_tbus_read_data), .ldu_tbus_operation_done(ldu_tbus_operation_done),
    .ldu_flush(ldu_flush),
    .stu_tbus_index_valid(stu_tbus_index_valid), .stu_tbus_index_ready(stu_tbus_index_ready),
    .stu_tbus_index(stu_tbus_index), .stu_tbus_write_data(stu_tbus_write_data),
    .stu_tbus_write_mask(stu_tbus_write_mask), .stu_tbus_operation_type(stu_tbus_operation_type),
    .stu_tbus_read_data(stu_tbus_read_data), .stu_tbus_operation_done(stu_tbus_operation_done),
    .tbus_index_valid(tbus_index_valid), .tbus_index_ready(tbus_index_ready),
    .tbus_index(tbus_index), .tbus_write_data(tbus_write_data), .tbus_write_mask(tbus_write_mask),
    .tbus_operation_type(tbus_operation_type), .tbus_read_data(tbus_read_data),
    .tbus_operation_done(tbus_operation_done), .arb_busy(arb_busy)
  );

  tbus_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clock(clock), .reset(reset),
    .ldu_tbus_index_valid(ldu_tbus_index_valid), .ldu_tbus_index_ready(f_ldu_ready),
    .ldu_tbus_index(ldu_tbus_index), .ldu_tbus_write_data(ldu_tbus_write_data),
    .ldu_tbus_write_mask(ldu_tbus_write_mask), .ldu_tbus_operation_type(ldu_tbus_operation_type),
    .ldu_tbus_read_data(f_ldu_rd), .ldu_tbus_operation_done(f_ldu_done),
    .ldu_flush(ldu_flush),
    .stu_tbus_index_valid(stu_tbus_index_valid), .stu_tbus_index_ready(f_stu_ready),
    .stu_tbus_index(stu_tbus_index), .stu_tbus_write_data(stu_tbus_write_data),
    .stu_tbus_write_mask(stu_tbus_write_mask), .stu_tbus_operation_type(stu_tbus_operation_type),
    .stu_tbus_read_data(f_stu_rd), .stu_tbus_operation_done(f_stu_done),
    .tbus_index_valid(f_tbus_valid), .tbus_index_ready(tbus_index_ready),
    .tbus_index(f_tbus_index), .tbus_write_data(f_tbus_wd), .tbus_write_mask(f_tbus_wm),
    .tbus_operation_type(f_tbus_op), .tbus_read_data(tbus_read_data),
    .tbus_operation_done(tbus_operation_done), .arb_busy(f_busy)
  );

  task automatic test_reset();
    reset = 1'b1;
    ldu_tbus_index_valid = 1'b1;
    stu_tbus_index_valid = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++; if (ldu_tbus_index_ready !== 1'b0) $display("FAIL reset_ldu_ready got %b exp 0", ldu_tbus_index_ready); else n_pass++;
    n_checks++; if (stu_tbus_index_ready !== 1'b0) $display("FAIL reset_stu_ready got %b exp 0", stu_tbus_index_ready); else n_pass++;
    n_checks++; if (arb_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", arb_busy); else n_pass++;
    n_checks++; if (tbus_index_valid !== 1'b0) $display("FAIL reset_tbus_valid got %b exp 0", tbus_index_valid); else n_pass++;
    n_checks++; if (tbus_index !== 64'h0) $display("FAIL reset_tbus_index got %h exp 0", tbus_index); else n_pass++;
    ldu_tbus_index_valid = 1'b0;
    stu_tbus_index_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_contention();
    exp_t e, f;
    int   t;
    ldu_tbus_index = 64'h1000; ldu_tbus_operation_type = 2'b00;
    stu_tbus_index = 64'h2000; stu_tbus_operation_type = 2'b01;
    stu_tbus_write_data = 64'h55; stu_tbus_write_mask = 64'hFF;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i % 2 == 0) ? {1'b0, 64'h1000, 2'b00, 64'h0, 64'h0}
                                   : {1'b1, 64'h2000, 2'b01, 64'h55, 64'hFF});
      fp_q.push_back({1'b0, 64'h1000, 2'b00, 64'h0, 64'h0});
    end
    @(posedge clock); #1;
    ldu_tbus_index_valid = 1'b1;
    stu_tbus_index_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      @(negedge clock);
      while (!tbus_index_valid && t < 20) begin @(negedge clock); t++; end
      n_checks++; if (tbus_index_valid !== 1'b1) $display("FAIL cont_req_timeout txn %0d valid %b exp 1", i, tbus_index_valid); else n_pass++;
      e = exp_q.pop_front();
      f = fp_q.pop_front();
      n_checks++; if (tbus_index !== e.idx || tbus_operation_type !== e.op) $display("FAIL cont_rr_grant txn %0d got %h/%b exp %h/%b", i, tbus_index, tbus_operation_type, e.idx, e.op); else n_pass++;
      n_checks++; if (f_tbus_valid !== 1'b1 || f_tbus_index !== f.idx) $display("FAIL cont_fp_grant txn %0d got %b/%h exp 1/%h", i, f_tbus_valid, f_tbus_index, f.idx); else n_pass++;
      tbus_index_ready = 1'b1;
      @(posedge clock); #1;
      tbus_index_ready = 1'b0;
      tbus_operation_done = 1'b1;
      tbus_read_data = 64'hC0DE_0000 + 64'(i);
      if (i == 3) begin ldu_tbus_index_valid = 1'b0; stu_tbus_index_valid = 1'b0; end
      @(negedge clock);
      n_checks++; if (ldu_tbus_operation_done !== ~e.own || stu_tbus_operation_done !== e.own) $display("FAIL cont_rr_done txn %0d got ldu %b stu %b exp ldu %b stu %b", i, ldu_tbus_operation_done, stu_tbus_operation_done, ~e.own, e.own); else n_pass++;
      n_checks++; if (f_ldu_done !== 1'b1 || f_stu_done !== 1'b0) $display("FAIL cont_fp_done txn %0d got ldu %b stu %b exp ldu 1 stu 0", i, f_ldu_done, f_stu_done); else n_pass++;
      @(posedge clock); #1;
      tbus_operation_done = 1'b0;
    end
    @(negedge clock);
    n_checks++; if (arb_busy !== 1'b0) $display("FAIL cont_idle_after got busy %b exp 0", arb_busy); else n_pass++;
  endtask

  task automatic test_single_load();
    exp_t e;
    @(posedge clock); #1;
    ldu_tbus_index_valid = 1'b1; ldu_tbus_index = 64'h8000_1008; ldu_tbus_operation_type = 2'b00;
    exp_q.push_back({1'b0, 64'h8000_1008, 2'b00, 64'h0, 64'h0});
    @(negedge clock);
    n_checks++; if (ldu_tbus_index_ready !== 1'b1) $display("FAIL load_ready got %b exp 1", ldu_tbus_index_ready); else n_pass++;
    @(posedge clock); #1;
    ldu_tbus_index_valid = 1'b0;
    @(negedge clock);
    e = exp_q.pop_front();
    n_checks++; if (ldu_tbus_index_ready !== 1'b0) $display("FAIL load_ready_once got %b exp 0", ldu_tbus_index_ready); else n_pass++;
    n_checks++; if (tbus_index_valid !== 1'b1 || tbus_index !== e.idx || tbus_operation_type !== e.op) $display("FAIL load_req got %b %h %b exp 1 %h %b", tbus_index_valid, tbus_index, tbus_operation_type, e.idx, e.op); else n_pass++;
    @(negedge clock);
    n_checks++; if (tbus_index_valid !== 1'b1 || tbus_index !== e.idx) $display("FAIL load_req_hold got %b %h exp 1 %h", tbus_index_valid, tbus_index, e.idx); else n_pass++;
    tbus_index_ready = 1'b1;
    @(posedge clock); #1;
    tbus_index_ready = 1'b0;
    @(negedge clock);
    n_checks++; if (tbus_index_valid !== 1'b0 || tbus_index !== 64'h0 || arb_busy !== 1'b1) $display("FAIL load_wait got valid %b idx %h busy %b exp 0 0 1", tbus_index_valid, tbus_index, arb_busy); else n_pass++;
    n_checks++; if (ldu_tbus_operation_done !== 1'b0 || ldu_tbus_read_data !== 64'h0) $display("FAIL load_early_done got %b %h exp 0 0", ldu_tbus_operation_done, ldu_tbus_read_data); else n_pass++;
    @(posedge clock); @(posedge clock); #1;
    tbus_operation_done = 1'b1; tbus_read_data = 64'h1122_3344_5566_7788;
    @(negedge clock);
    n_checks++; if (ldu_tbus_operation_done !== 1'b1 || ldu_tbus_read_data !== 64'h1122_3344_5566_7788) $display("FAIL load_done got %b %h exp 1 1122334455667788", ldu_tbus_operation_done, ldu_tbus_read_data); else n_pass++;
    n_checks++; if (stu_tbus_operation_done !== 1'b0 || stu_tbus_read_data !== 64'h0) $display("FAIL load_stu_quiet got %b %h exp 0 0", stu_tbus_operation_done, stu_tbus_read_data); else n_pass++;
    @(posedge clock); #1;
    tbus_operation_done = 1'b0;
    @(negedge clock);
    n_checks++; if (ldu_tbus_operation_done !== 1'b0 || ldu_tbus_read_data !== 64'h0 || arb_busy !== 1'b0) $display("FAIL load_after got done %b rd %h busy %b exp 0 0 0", ldu_tbus_operation_done, ldu_tbus_read_data, arb_busy); else n_pass++;
  endtask

  task automatic test_store();
    exp_t e;
    @(posedge clock); #1;
    stu_tbus_index_valid = 1'b1; stu_tbus_index = 64'h100; stu_tbus_operation_type = 2'b01;
    stu_tbus_write_data = 64'hDEAD_BEEF; stu_tbus_write_mask = 64'h0F;
    exp_q.push_back({1'b1, 64'h100, 2'b01, 64'hDEAD_BEEF, 64'h0F});
    @(negedge clock);
    n_checks++; if (stu_tbus_index_ready !== 1'b1 || ldu_tbus_index_ready !== 1'b0) $display("FAIL store_ready got stu %b ldu %b exp 1 0", stu_tbus_index_ready, ldu_tbus_index_ready); else n_pass++;
    @(posedge clock); #1;
    stu_tbus_index_valid = 1'b0; stu_tbus_write_data = 64'h0;
    @(negedge clock);
    e = exp_q.pop_front();
    n_checks++; if (tbus_index !== e.idx || tbus_operation_type !== e.op || tbus_write_data !== e.wd || tbus_write_mask !== e.wm)
      $display("FAIL store_fields got %h %b %h %h exp %h %b %h %h", tbus_index, tbus_operation_type, tbus_write_data, tbus_write_mask, e.idx, e.op, e.wd, e.wm); else n_pass++;
    tbus_index_ready = 1'b1;
    @(posedge clock); #1;
    tbus_index_ready = 1'b0; tbus_operation_done = 1'b1; tbus_read_data = 64'h77;
    @(negedge clock);
    n_checks++; if (stu_tbus_operation_done !== 1'b1 || ldu_tbus_operation_done !== 1'b0) $display("FAIL store_done got stu %b ldu %b exp 1 0", stu_tbus_operation_done, ldu_tbus_operation_done); else n_pass++;
    @(posedge clock); #1;
    tbus_operation_done = 1'b0;
  endtask

  task automatic test_flush_wait();
    exp_t e;
    @(posedge clock); #1;
    ldu_tbus_index_valid = 1'b1; ldu_tbus_index = 64'h300; ldu_tbus_operation_type = 2'b00;
    @(negedge clock);
    n_checks++; if (ldu_tbus_index_ready !== 1'b1) $display("FAIL fw_ready got %b exp 1", ldu_tbus_index_ready); else n_pass++;
    @(posedge clock); #1;
    ldu_tbus_index_valid = 1'b0;
    @(negedge clock);
    tbus_index_ready = 1'b1;
    @(posedge clock); #1;
    tbus_index_ready = 1'b0; ldu_flush = 1'b1;
    @(posedge clock); #1;
    ldu_flush = 1'b0; tbus_operation_done = 1'b1; tbus_read_data = 64'hAAAA;
    stu_tbus_index_valid = 1'b1; stu_tbus_index = 64'h400; stu_tbus_operation_type = 2'b00;
    exp_q.push_back({1'b1, 64'h400, 2'b00, 64'h0, 64'h0});
    @(negedge clock);
    n_checks++; if (ldu_tbus_operation_done !== 1'b0 || ldu_tbus_read_data !== 64'h0) $display("FAIL fw_drain_done got %b %h exp 0 0", ldu_tbus_operation_done, ldu_tbus_read_data); else n_pass++;
    n_checks++; if (arb_busy !== 1'b1 || stu_tbus_index_ready !== 1'b0) $display("FAIL fw_drain_busy got busy %b stu_ready %b exp 1 0", arb_busy, stu_tbus_index_ready); else n_pass++;
    @(posedge clock); #1;
    tbus_operation_done = 1'b0;
    @(negedge clock);
    n_checks++; if (stu_tbus_index_ready !== 1'b1) $display("FAIL fw_next_grant got %b exp 1", stu_tbus_index_ready); else n_pass++;
    @(posedge clock); #1;
    stu_tbus_index_valid = 1'b0;
    @(negedge clock);
    e = exp_q.pop_front();
    n_checks++; if (tbus_index_valid !== 1'b1 || tbus_index !== e.idx) $display("FAIL fw_next_req got %b %h exp 1 %h", tbus_index_valid, tbus_index, e.idx); else n_pass++;
    tbus_index_ready = 1'b1;
    @(posedge clock); #1;
    tbus_index_ready = 1'b0; tbus_operation_done = 1'b1;
    @(negedge clock);
    n_checks++; if (stu_tbus_operation_done !== e.own) $display("FAIL fw_next_done got %b exp %b", stu_tbus_operation_done, e.own); else n_pass++;
    @(posedge clock); #1;
    tbus_operation_done = 1'b0;
  endtask

  task automatic test_flush_req();
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      ldu_tbus_index_valid = 1'b1; ldu_tbus_index = 64'h500 + 64'(k * 256);
      @(posedge clock); #1;
      ldu_tbus_index_valid = 1'b0;
      @(negedge clock);
      n_checks++; if (tbus_index_valid !== 1'b1) $display("FAIL fr_req%0d got %b exp 1", k, tbus_index_valid); else n_pass++;
      @(posedge clock); #1;
      ldu_flush = 1'b1; tbus_index_ready = (k == 1);
      @(posedge clock); #1;
      ldu_flush = 1'b0; tbus_index_ready = 1'b0;
      @(negedge clock);
      n_checks++; if (tbus_index_valid !== 1'b0 || arb_busy !== (k == 1)) $display("FAIL fr_after%0d got valid %b busy %b exp 0 %b", k, tbus_index_valid, arb_busy, (k == 1)); else n_pass++;
    end
    @(posedge clock); #1;
    tbus_operation_done = 1'b1; tbus_read_data = 64'h99;
    @(negedge clock);
    n_checks++; if (ldu_tbus_operation_done !== 1'b0 || ldu_tbus_read_data !== 64'h0) $display("FAIL fr_drain_done got %b %h exp 0 0", ldu_tbus_operation_done, ldu_tbus_read_data); else n_pass++;
    @(posedge clock); #1;
    tbus_operation_done = 1'b0;
    @(negedge clock);
    n_checks++; if (arb_busy !== 1'b0) $display("FAIL fr_idle got busy %b exp 0", arb_busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(posedge clock); #1;
    stu_tbus_index_valid = 1'b1; stu_tbus_index = 64'h700; stu_tbus_operation_type = 2'b01;
    stu_tbus_write_data = 64'h1234; stu_tbus_write_mask = 64'hFF;
    @(posedge clock); #1;
    stu_tbus_index_valid = 1'b0;
    @(negedge clock);
    tbus_index_ready = 1'b1;
    @(posedge clock); #1;
    tbus_index_ready = 1'b0;
    @(negedge clock);
    n_checks++; if (arb_busy !== 1'b1) $display("FAIL rm_wait_busy got %b exp 1", arb_busy); else n_pass++;
    reset = 1'b1; stu_tbus_index_valid = 1'b1;
    #1;
    n_checks++; if (arb_busy !== 1'b0 || tbus_index_valid !== 1'b0 || tbus_index !== 64'h0 || tbus_write_data !== 64'h0)
      $display("FAIL rm_async got busy %b valid %b idx %h wd %h exp all 0", arb_busy, tbus_index_valid, tbus_index, tbus_write_data); else n_pass++;
    n_checks++; if (stu_tbus_index_ready !== 1'b0 || stu_tbus_operation_done !== 1'b0) $display("FAIL rm_req_outs got ready %b done %b exp 0 0", stu_tbus_index_ready, stu_tbus_operation_done); else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0; stu_tbus_index_valid = 1'b0; tbus_operation_done = 1'b1; tbus_read_data = 64'hBAD;
    @(negedge clock);
    n_checks++; if (ldu_tbus_operation_done !== 1'b0 || stu_tbus_operation_done !== 1'b0 || stu_tbus_read_data !== 64'h0 || arb_busy !== 1'b0)
      $display("FAIL rm_stray_done got ldu %b stu %b rd %h busy %b exp 0 0 0 0", ldu_tbus_operation_done, stu_tbus_operation_done, stu_tbus_read_data, arb_busy); else n_pass++;
    @(posedge clock); #1;
    tbus_operation_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0;
    reset = 1'b1;
    ldu_tbus_index_valid = 1'b0; ldu_tbus_index = '0; ldu_tbus_write_data = '0;
    ldu_tbus_write_mask = '0; ldu_tbus_operation_type = '0; ldu_flush = 1'b0;
    stu_tbus_index_valid = 1'b0; stu_tbus_index = '0; stu_tbus_write_data = '0;
    stu_tbus_write_mask = '0; stu_tbus_operation_type = '0;
    tbus_index_ready = 1'b0; tbus_read_data = '0; tbus_operation_done = 1'b0;
    test_reset();
    test_contention();
    test_single_load();
    test_store();
    test_flush_wait();
    test_flush_req();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
